control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 32 +++
 rtl/control_sequencer_pc_next.sv | 14 +
 rtl/control_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer and the decode FSM.
package control_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_P0,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_HALT
   } state_t;

   localparam logic [7:0] S_NONE = 8'h00;
   localparam logic [7:0] S_P0   = 8'h01;
   localparam logic [7:0] S_P1   = 8'h02;
   localparam logic [7:0] S_P2   = 8'h04;
   localparam logic [7:0] S_P3   = 8'h08;

   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;

   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_ADD) || (op == OP_BEQ) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/control_sequencer_pc_next.sv
// Combinational next-PC: sequential step, or branch target when take_br is set.
module control_sequencer_pc_next
   import control_sequencer_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] br_off,
   input  logic        take_br,
   output logic [31:0] pc_nxt
);

   // Plain 32-bit adds: wrap-around modulo 2^32 is intended.
   assign pc_nxt = take_br ? (pc + br_off) : (pc + PC_STEP);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/phase sequencer: fetches an instruction word, then steps the decode FSM
// through one-hot phases S0..S3 and advances the PC; illegal opcodes halt until reset.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [6:0]  OpI,
   input  logic        br_taken,
   input  logic [31:0] br_off,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [7:0]  S,
   output logic [31:0] datain,
   output logic [31:0] PC,
   output logic        halt
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] datain_q, datain_d;
   logic        is_beq;
   logic        take_br;
   logic [31:0] pc_nxt;

   assign is_beq = (OpI == OP_BEQ);

   control_sequencer_pc_next u_pc_next (
      .pc      (pc_q),
      .br_off  (br_off),
      .take_br (take_br),
      .pc_nxt  (pc_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (run) state_d = ST_FETCH;
         ST_FETCH: if (mem_ack) state_d = ST_P0;
         ST_P0:    state_d = ST_P1;
         ST_P1:    state_d = is_legal_op(OpI) ? ST_P2 : ST_HALT;
         ST_P2:    begin
            if (is_beq) state_d = run ? ST_FETCH : ST_IDLE;
            else        state_d = ST_P3;
         end
         ST_P3:    state_d = run ? ST_FETCH : ST_IDLE;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req  = (state_q == ST_FETCH);
      mem_addr = mem_req ? pc_q : '0;
      halt     = (state_q == ST_HALT);
      unique case (state_q)
         ST_P0:   S = S_P0;
         ST_P1:   S = S_P1;
         ST_P2:   S = S_P2;
         ST_P3:   S = S_P3;
         default: S = S_NONE;
      endcase
   end

   // PC only moves at end of instruction: P2 for beq, P3 otherwise.
   always_comb begin
      pc_d     = pc_q;
      datain_d = datain_q;
      take_br  = (state_q == ST_P2) && is_beq && br_taken;
      if ((state_q == ST_FETCH) && mem_ack) begin
         datain_d = mem_rdata;
      end
      if (((state_q == ST_P2) && is_beq) || (state_q == ST_P3)) begin
         pc_d = pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         datain_q <= '0;
      end else begin
         pc_q     <= pc_d;
         datain_q <= datain_d;
      end
   end

   assign PC     = pc_q;
   assign datain = datain_q;

endmodule
